imem_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the single-cycle/multi-cycle MIPS core.
- Owns the PC and drives the address of the combinational instruction ROM (32 words, index = address[6:2]).
- Registers the returned word into an output instruction register with a valid/ready handshake toward decode.
- Handles start, branch/jump redirect with flush, and halt-on-sentinel.

---
 rtl/imem_fetch_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction-fetch sequencer for the MIPS core. It owns the PC and drives the
// address of the combinational instruction ROM. The returned word is captured
// into an output instruction register, which is handed to decode with a
// valid/ready handshake. The block also handles start, branch/jump redirect
// with flush, and stopping on a halt sentinel instruction.
//
// Parameters:
//   RESET_PC   PC loaded at reset and on start from HALT
//   MEM_WORDS  ROM depth in words; the sequential PC wraps to 0 after the last word
//   HALT_INST  sentinel instruction that stops fetching
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 one-cycle pulse that leaves IDLE or HALT
//   imem_addr / imem_data ROM byte address (the PC register) and read data
//   inst, inst_pc         registered instruction and its PC
//   inst_valid/inst_ready handshake toward decode
//   redirect_valid/_pc    taken branch/jump and its target byte address
//   halted                high while in HALT
//   fetch_count           transfer counter (only with IMEM_FETCH_PERF_EN)
//   stall_count           back-pressure cycles in RUN (only with IMEM_FETCH_PERF_EN)
//
// Optional feature macro: IMEM_FETCH_PERF_EN (adds saturating perf counters).
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 32,
    parameter logic [31:0] HALT_INST = 32'h0000_000C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [31:0] LAST_PC_C = 32'((MEM_WORDS - 1) * 4);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_HALT_PEND = 2'd2,
        ST_HALT      = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] inst_r, inst_s;
    logic [31:0] inst_pc_r, inst_pc_s;
    logic        inst_valid_r, inst_valid_s;
    logic        halted_r, halted_s;
    logic        ld_s;
    logic        xfer_s;

    // Sequential successor of a PC; wraps only on sequential increment.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        if (pc == LAST_PC_C) begin
            return 32'h0000_0000;
        end else begin
            return pc + 32'd4;
        end
    endfunction

    // Redirect targets are forced to word alignment.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    // Next-state, PC and instruction-register logic.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        inst_s       = inst_r;
        inst_pc_s    = inst_pc_r;
        inst_valid_s = inst_valid_r;
        halted_s     = halted_r;
        ld_s         = !inst_valid_r || inst_ready;
        xfer_s       = inst_valid_r && inst_ready;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Redirect flushes the register and overrides any load or transfer.
                if (redirect_valid) begin
                    pc_s         = align_pc(redirect_pc);
                    inst_valid_s = 1'b0;
                end else if (ld_s) begin
                    inst_s       = imem_data;
                    inst_pc_s    = pc_r;
                    inst_valid_s = 1'b1;
                    // A captured sentinel freezes the PC on the halt word.
                    if (imem_data == HALT_INST) begin
                        state_s = ST_HALT_PEND;
                    end else begin
                        pc_s = seq_pc(pc_r);
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_HALT_PEND: begin
                if (redirect_valid) begin
                    pc_s         = align_pc(redirect_pc);
                    inst_valid_s = 1'b0;
                    state_s      = ST_RUN;
                end else if (xfer_s) begin
                    inst_valid_s = 1'b0;
                    halted_s     = 1'b1;
                    state_s      = ST_HALT;
                end else begin
                    state_s = ST_HALT_PEND;
                end
            end
            ST_HALT: begin
                if (start) begin
                    pc_s     = RESET_PC;
                    halted_s = 1'b0;
                    state_s  = ST_RUN;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s      = ST_IDLE;
                pc_s         = RESET_PC;
                inst_valid_s = 1'b0;
                halted_s     = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            inst_r       <= 32'h0000_0000;
            inst_pc_r    <= 32'h0000_0000;
            inst_valid_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            inst_r       <= inst_s;
            inst_pc_r    <= inst_pc_s;
            inst_valid_r <= inst_valid_s;
            halted_r     <= halted_s;
        end
    end

    assign imem_addr  = pc_r;
    assign inst       = inst_r;
    assign inst_pc    = inst_pc_r;
    assign inst_valid = inst_valid_r;
    assign halted     = halted_r;

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] stall_cnt_r;
    logic        cnt_clr_s;
    logic        cnt_xfer_s;
    logic        cnt_stall_s;

    // Counter events; a redirect cancels the transfer in the same cycle.
    always_comb begin
        cnt_clr_s   = start && ((state_r == ST_IDLE) || (state_r == ST_HALT));
        cnt_xfer_s  = inst_valid_r && inst_ready && !redirect_valid;
        cnt_stall_s = (state_r == ST_RUN) && inst_valid_r && !inst_ready;
    end

    // Saturating performance counters, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_r <= 32'h0000_0000;
            stall_cnt_r <= 32'h0000_0000;
        end else if (cnt_clr_s) begin
            fetch_cnt_r <= 32'h0000_0000;
            stall_cnt_r <= 32'h0000_0000;
        end else begin
            if (cnt_xfer_s && (fetch_cnt_r != 32'hFFFF_FFFF)) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end else begin
                fetch_cnt_r <= fetch_cnt_r;
            end
            if (cnt_stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign fetch_count = fetch_cnt_r;
    assign stall_count = stall_cnt_r;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Directed scenarios followed by a randomized run. The randomized run is
// checked against a stream model: the program order of delivered
// instructions, start/halt/redirect events and the PC look-ahead on imem_addr.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    localparam logic [31:0] HALT_C = 32'h0000_000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        halted;
`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    logic [31:0] rom [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_data = rom[imem_addr[6:2]];

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
`ifdef IMEM_FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] p);
        return (p == 32'd124) ? 32'd0 : p + 32'd4;
    endfunction

    logic [31:0] m_expect;
    logic        m_active;
    logic        m_halted;
    int          noval;
    logic        ev;

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = $urandom | 32'h8000_0000;
        rom[8] = HALT_C;

        // Reset values
        #3;
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        #10 rst_n = 1'b1;
        tick();

        // Redirect in IDLE is ignored
        redirect_valid = 1'b1;
        redirect_pc    = 32'h50;
        tick();
        redirect_valid = 1'b0;
        chk("idle_redir_addr", imem_addr, 32'h0);
        chk("idle_redir_valid", {31'd0, inst_valid}, 32'd0);

        // Straight-line run up to the sentinel at word 8
        inst_ready = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("start_addr", imem_addr, 32'h0);
        chk("start_valid", {31'd0, inst_valid}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("seq_valid", {31'd0, inst_valid}, 32'd1);
            chk("seq_pc", inst_pc, 32'(i * 4));
            chk("seq_inst", inst, rom[i]);
        end
        chk("pend_halted", {31'd0, halted}, 32'd0);
        chk("pend_addr", imem_addr, 32'h20);
        tick();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_valid", {31'd0, inst_valid}, 32'd0);
        chk("halt_addr", imem_addr, 32'h20);
        tick();
        tick();
        chk("halt_frozen_addr", imem_addr, 32'h20);
        chk("halt_frozen_h", {31'd0, halted}, 32'd1);
`ifdef IMEM_FETCH_PERF_EN
        chk("perf_fetch", fetch_count, 32'd9);
        chk("perf_stall", stall_count, 32'd0);
`endif

        // Restart from HALT, then back-pressure on inst_pc=0x08
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_halted", {31'd0, halted}, 32'd0);
        tick();
        tick();
        tick();
        chk("bp_pre_pc", inst_pc, 32'h08);
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_pc", inst_pc, 32'h08);
            chk("bp_inst", inst, rom[2]);
            chk("bp_addr", imem_addr, 32'h0C);
            chk("bp_valid", {31'd0, inst_valid}, 32'd1);
        end
        inst_ready = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("bp_rel_pc", inst_pc, 32'h0C);
        chk("bp_rel_addr", imem_addr, 32'h10);

        // Redirect to unaligned 0x15
        redirect_valid = 1'b1;
        redirect_pc    = 32'h15;
        tick();
        redirect_valid = 1'b0;
        chk("redir_flush", {31'd0, inst_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h14);
        tick();
        chk("redir_valid", {31'd0, inst_valid}, 32'd1);
        chk("redir_pc", inst_pc, 32'h14);
        chk("redir_inst", inst, rom[5]);

        // Redirect in the same cycle as the sentinel load
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1C;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("rh_pre_pc", inst_pc, 32'h1C);
        chk("rh_pre_addr", imem_addr, 32'h20);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("rh_flush", {31'd0, inst_valid}, 32'd0);
        chk("rh_halted", {31'd0, halted}, 32'd0);
        chk("rh_addr", imem_addr, 32'h40);
        tick();
        chk("rh_pc", inst_pc, 32'h40);
        chk("rh_inst", inst, rom[16]);
        chk("rh_halted2", {31'd0, halted}, 32'd0);

        // Wrap at the last ROM word
        redirect_valid = 1'b1;
        redirect_pc    = 32'h7C;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_last_pc", inst_pc, 32'h7C);
        chk("wrap_last_inst", inst, rom[31]);
        tick();
        chk("wrap_zero_pc", inst_pc, 32'h00);
        chk("wrap_zero_inst", inst, rom[0]);

        // Asynchronous reset mid-RUN, away from the clock edge
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, inst_valid}, 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
`ifdef IMEM_FETCH_PERF_EN
        chk("arst_fetch", fetch_count, 32'd0);
`endif
        #2 rst_n = 1'b1;
        tick();
        tick();
        chk("arst_idle_valid", {31'd0, inst_valid}, 32'd0);
        chk("arst_idle_addr", imem_addr, 32'h0);

        // Randomized run against the stream model
        for (int i = 0; i < 32; i++) rom[i] = $urandom | 32'h8000_0000;
        rom[$urandom_range(1, 31)] = HALT_C;
        rom[$urandom_range(1, 31)] = HALT_C;
        m_expect = 32'h0;
        m_active = 1'b0;
        m_halted = 1'b0;
        noval    = 0;
        for (int c = 0; c < 1500; c++) begin
            chk("r_halted", {31'd0, halted}, {31'd0, m_halted});
            if (m_halted) chk("r_halt_novalid", {31'd0, inst_valid}, 32'd0);
            if (inst_valid) begin
                chk("r_pc", inst_pc, m_expect);
                chk("r_inst", inst, rom[inst_pc[6:2]]);
                chk("r_addr", imem_addr, (inst == HALT_C) ? inst_pc : nxt(inst_pc));
            end else if (m_active) begin
                chk("r_addr_idle", imem_addr, m_expect);
                noval++;
                chk("r_live", {31'd0, noval > 1}, 32'd0);
            end

            inst_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            start          = m_active ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);

            ev = 1'b0;
            if (redirect_valid && m_active) begin
                m_expect = {redirect_pc[31:2], 2'b00};
                ev = 1'b1;
            end else if (start && !m_active) begin
                m_expect = 32'h0;
                m_active = 1'b1;
                m_halted = 1'b0;
                ev = 1'b1;
            end else if (inst_valid && inst_ready) begin
                if (inst == HALT_C) begin
                    m_active = 1'b0;
                    m_halted = 1'b1;
                end else begin
                    m_expect = nxt(m_expect);
                end
            end
            if (ev || inst_valid) noval = 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
